// File: rtl/bouncing_sprite_engine.sv
// Bouncing sprite overlay: two-stage pixel pipeline against a 1-cycle sprite ROM plus per-frame motion.
// Optional transparent colour key is enabled by defining SPRITE_COLORKEY_EN.
module bouncing_sprite_engine #(
   parameter int H_RES   = 640,
   parameter int V_RES   = 480,
   parameter int SPR_W   = 100,
   parameter int SPR_H   = 100,
   parameter int COORD_W = 10,
   parameter int ADDR_W  = 14,
   parameter int DATA_W  = 12,
   parameter int STEP    = 1,
   parameter int X0      = 100,
   parameter int Y0      = 100,
   parameter logic DX0   = 1'b0,
   parameter logic DY0   = 1'b1,
   parameter logic [DATA_W-1:0] BG_COLOR  = DATA_W'(12'h000),
   parameter logic [DATA_W-1:0] KEY_COLOR = DATA_W'(12'hF0F)
) (
   input  logic               pclk,
   input  logic               rst,
   input  logic [COORD_W-1:0] h_addr,
   input  logic [COORD_W-1:0] v_addr,
   input  logic               valid,
   input  logic               frame_tick,
   input  logic               move_en,
   input  logic [3:0]         speed,
   output logic [ADDR_W-1:0]  rom_addr,
   input  logic [DATA_W-1:0]  rom_data,
   output logic [DATA_W-1:0]  pix_out,
   output logic               pix_valid,
   output logic               in_sprite,
   output logic [COORD_W-1:0] spr_x,
   output logic [COORD_W-1:0] spr_y,
   output logic               dir_x,
   output logic               dir_y,
   output logic               bounce_x,
   output logic               bounce_y
);

   localparam int CW1   = COORD_W + 1;
   localparam int X_MAX = H_RES - SPR_W;
   localparam int Y_MAX = V_RES - SPR_H;

   logic [COORD_W-1:0] spr_x_q, spr_x_d;
   logic [COORD_W-1:0] spr_y_q, spr_y_d;
   logic               dir_x_q, dir_x_d;
   logic               dir_y_q, dir_y_d;
   logic               bounce_x_q, bounce_x_d;
   logic               bounce_y_q, bounce_y_d;
   logic [3:0]         cnt_q, cnt_d;

   logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
   logic               area1_q, valid1_q;
   logic               area2_q, valid2_q;

   logic [CW1-1:0]     h_ext, v_ext, x_lo, y_lo, x_hi, y_hi;
   logic               in_area;
   logic [COORD_W-1:0] dx, dy;
   logic [CW1-1:0]     x_fwd, y_fwd;
   logic               key_hit;

   // Widened compare so spr_x+SPR_W cannot wrap at the right/bottom edge.
   always_comb begin
      h_ext   = {1'b0, h_addr};
      v_ext   = {1'b0, v_addr};
      x_lo    = {1'b0, spr_x_q};
      y_lo    = {1'b0, spr_y_q};
      x_hi    = x_lo + CW1'(SPR_W);
      y_hi    = y_lo + CW1'(SPR_H);
      in_area = valid && (h_ext >= x_lo) && (h_ext < x_hi) && (v_ext >= y_lo) && (v_ext < y_hi);
      dx      = h_addr - spr_x_q;
      dy      = v_addr - spr_y_q;
   end

   always_comb begin
      rom_addr_d = rom_addr_q;
      if (in_area) begin
         rom_addr_d = ADDR_W'(dy) * ADDR_W'(SPR_W) + ADDR_W'(dx);
      end
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         rom_addr_q <= '0;
         area1_q    <= 1'b0;
         valid1_q   <= 1'b0;
         area2_q    <= 1'b0;
         valid2_q   <= 1'b0;
      end else begin
         rom_addr_q <= rom_addr_d;
         area1_q    <= in_area;
         valid1_q   <= valid;
         area2_q    <= area1_q;
         valid2_q   <= valid1_q;
      end
   end

`ifdef SPRITE_COLORKEY_EN
   assign key_hit = area2_q && (rom_data == KEY_COLOR);
`else
   assign key_hit = 1'b0;
`endif

   // rom_data lines up with the stage-2 flags, so the final mux is combinational.
   always_comb begin
      in_sprite = area2_q && !key_hit;
      pix_valid = valid2_q;
      if (in_sprite) begin
         pix_out = rom_data;
      end else if (valid2_q) begin
         pix_out = BG_COLOR;
      end else begin
         pix_out = '0;
      end
   end

   always_comb begin
      spr_x_d    = spr_x_q;
      spr_y_d    = spr_y_q;
      dir_x_d    = dir_x_q;
      dir_y_d    = dir_y_q;
      bounce_x_d = 1'b0;
      bounce_y_d = 1'b0;
      cnt_d      = cnt_q;
      x_fwd      = {1'b0, spr_x_q} + CW1'(STEP);
      y_fwd      = {1'b0, spr_y_q} + CW1'(STEP);
      if (frame_tick && move_en) begin
         // >= so a speed lowered below the running count still triggers on the next tick
         if (cnt_q >= speed) begin
            cnt_d = '0;
            if (!dir_x_q) begin
               if (x_fwd >= CW1'(X_MAX)) begin
                  spr_x_d    = COORD_W'(X_MAX);
                  dir_x_d    = 1'b1;
                  bounce_x_d = 1'b1;
               end else begin
                  spr_x_d = x_fwd[COORD_W-1:0];
               end
            end else if (spr_x_q <= COORD_W'(STEP)) begin
               spr_x_d    = '0;
               dir_x_d    = 1'b0;
               bounce_x_d = 1'b1;
            end else begin
               spr_x_d = spr_x_q - COORD_W'(STEP);
            end
            if (!dir_y_q) begin
               if (y_fwd >= CW1'(Y_MAX)) begin
                  spr_y_d    = COORD_W'(Y_MAX);
                  dir_y_d    = 1'b1;
                  bounce_y_d = 1'b1;
               end else begin
                  spr_y_d = y_fwd[COORD_W-1:0];
               end
            end else if (spr_y_q <= COORD_W'(STEP)) begin
               spr_y_d    = '0;
               dir_y_d    = 1'b0;
               bounce_y_d = 1'b1;
            end else begin
               spr_y_d = spr_y_q - COORD_W'(STEP);
            end
         end else begin
            cnt_d = cnt_q + 4'd1;
         end
      end
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         spr_x_q    <= COORD_W'(X0);
         spr_y_q    <= COORD_W'(Y0);
         dir_x_q    <= DX0;
         dir_y_q    <= DY0;
         bounce_x_q <= 1'b0;
         bounce_y_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         spr_x_q    <= spr_x_d;
         spr_y_q    <= spr_y_d;
         dir_x_q    <= dir_x_d;
         dir_y_q    <= dir_y_d;
         bounce_x_q <= bounce_x_d;
         bounce_y_q <= bounce_y_d;
         cnt_q      <= cnt_d;
      end
   end

   assign rom_addr = rom_addr_q;
   assign spr_x    = spr_x_q;
   assign spr_y    = spr_y_q;
   assign dir_x    = dir_x_q;
   assign dir_y    = dir_y_q;
   assign bounce_x = bounce_x_q;
   assign bounce_y = bounce_y_q;

endmodule
